// File: rtl/level_ctrl.sv
// level_ctrl: game state, level and lives controller with a per-level obstacle tick generator.
module level_ctrl #(
  parameter int P1       = 131072,
  parameter int P2       = 65536,
  parameter int P3       = 32768,
  parameter int P4       = 4096,
  parameter int HOLD_CYC = 1024,
  parameter int LIVES    = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       win,
  input  logic       death,
  input  logic       pause,
  output logic       enable,
  output logic [1:0] level,
  output logic [1:0] lives,
  output logic [2:0] state,
  output logic       level_up
);
  typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, PAUSE = 3'd2, HOLD = 3'd3, OVER = 3'd4, DONE = 3'd5} st_t;
  localparam logic [16:0] M1 = 17'(P1 - 1);
  localparam logic [16:0] M2 = 17'(P2 - 1);
  localparam logic [16:0] M3 = 17'(P3 - 1);
  localparam logic [16:0] M4 = 17'(P4 - 1);
  localparam logic [15:0] HM = 16'(HOLD_CYC - 1);
  localparam logic [1:0]  LV = 2'(LIVES);
  st_t         st, st_n;
  logic [16:0] cnt, cnt_n, pmax;
  logic [15:0] hcnt, hcnt_n;
  logic [1:0]  level_n, lives_n;
  logic        en_n, lu_n;
  assign pmax  = level == 2'd0 ? M1 : level == 2'd1 ? M2 : level == 2'd2 ? M3 : M4;
  assign state = st;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st       <= IDLE;
      level    <= 2'd0;
      lives    <= LV;
      cnt      <= '0;
      hcnt     <= '0;
      enable   <= 1'b0;
      level_up <= 1'b0;
    end else begin
      st       <= st_n;
      level    <= level_n;
      lives    <= lives_n;
      cnt      <= cnt_n;
      hcnt     <= hcnt_n;
      enable   <= en_n;
      level_up <= lu_n;
    end
  // The tick counter only advances on PLAY cycles that stay in PLAY, so the edge that leaves never ticks.
  always_comb begin
    st_n    = st;
    level_n = level;
    lives_n = lives;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    en_n    = 1'b0;
    lu_n    = 1'b0;
    case (st)
      IDLE, OVER, DONE:
        if (start) begin
          st_n    = PLAY;
          level_n = 2'd0;
          lives_n = LV;
          cnt_n   = '0;
        end
      PLAY:
        if (death) begin
          lives_n = lives == 2'd0 ? 2'd0 : lives - 2'd1;
          st_n    = lives <= 2'd1 ? OVER : HOLD;
          hcnt_n  = '0;
        end else if (win) begin
          if (level == 2'd3) st_n = DONE;
          else begin
            level_n = level + 2'd1;
            lu_n    = 1'b1;
            st_n    = HOLD;
            hcnt_n  = '0;
          end
        end else if (pause) st_n = PAUSE;
        else begin
          en_n  = cnt == pmax;
          cnt_n = en_n ? '0 : cnt + 17'd1;
        end
      PAUSE:
        if (pause) st_n = PLAY;
      HOLD:
        if (hcnt == HM) begin
          st_n  = PLAY;
          cnt_n = '0;
        end else hcnt_n = hcnt + 16'd1;
      default: st_n = IDLE;
    endcase
  end
endmodule
